perceptron_arb: RTL and testbench

PERCEPTRON_ARB -- requirements
Module: perceptron_arb

---
 rtl/perceptron_pkg.sv | 20 ++
 rtl/perceptron_tag_fifo.sv | 58 +++++
 rtl/perceptron_arb.sv | 140 ++++++++++++++
 tb/tb_perceptron_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron arbiter: bus width defaults, tag depth, requester ID.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package perceptron_pkg;

   localparam int P_DW        = 8;
   localparam int P_OW        = 8;
   localparam int P_TAG_DEPTH = 4;

   // Grant counters saturate here instead of wrapping.
   localparam logic [15:0] P_CNT_MAX = 16'hFFFF;

   // Identifies which requester owns an in-flight transaction.
   typedef enum logic {
      REQ_ID0 = 1'b0,
      REQ_ID1 = 1'b1
   } req_id_t;

endpackage

// File: rtl/perceptron_tag_fifo.sv
// Tag FIFO: remembers the requester ID of every transaction issued to the perceptron, in order.
// Latency: a push is visible at the head on the following cycle; head is read combinationally.
// Backpressure: caller must not push when full or pop when empty; full/empty are exported for that.
`timescale 1ns/1ps
module perceptron_tag_fifo
   import perceptron_pkg::*;
#(
   parameter int DEPTH = P_TAG_DEPTH
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    i_push,
   input  req_id_t i_push_id,
   input  logic    i_pop,
   output logic    o_full,
   output logic    o_empty,
   output req_id_t o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL_CNT = (AW+1)'(DEPTH);

   // DEPTH is a power of two, so the pointers wrap naturally at DEPTH.
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_cnt;
   req_id_t       r_mem [DEPTH];

   // Pointer, occupancy and storage update; a push and pop together leave r_cnt unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= REQ_ID0;
         end
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_push_id;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (i_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_full  = (r_cnt == L_FULL_CNT);
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/perceptron_arb.sv
// Two-requester round-robin arbiter in front of a shared perceptron, routing results back by tag.
// Latency: 0 cycles issue (combinational grant/data), 0 cycles result routing; optional grant stats via PERCEPTRON_ARB_STATS_EN.
// Backpressure: issue stalls on p_rdy_i low or tag FIFO full; results stall until the owning resp channel is ready.
`timescale 1ns/1ps
module perceptron_arb
   import perceptron_pkg::*;
#(
   parameter int DW        = P_DW,
   parameter int OW        = P_OW,
   parameter int TAG_DEPTH = P_TAG_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_val_i,
   input  logic [DW-1:0] req0_data_i,
   output logic          req0_rdy_o,
   input  logic          req1_val_i,
   input  logic [DW-1:0] req1_data_i,
   output logic          req1_rdy_o,
   output logic          p_val_o,
   output logic [DW-1:0] p_data_o,
   input  logic          p_rdy_i,
   input  logic          p_val_i,
   input  logic [OW-1:0] p_data_i,
   output logic          p_rdy_o,
   output logic          resp0_val_o,
   output logic [OW-1:0] resp0_data_o,
   input  logic          resp0_rdy_i,
   output logic          resp1_val_o,
   output logic [OW-1:0] resp1_data_o,
   input  logic          resp1_rdy_i,
   output logic          err_o,
   output logic [15:0]   gnt_cnt0_o,
   output logic [15:0]   gnt_cnt1_o
);

   logic    w_full;
   logic    w_empty;
   req_id_t w_head;
   logic    w_gnt0;
   logic    w_gnt1;
   req_id_t w_gnt_id;
   logic    w_issue;
   logic    w_head_rdy;
   logic    w_result;

   req_id_t r_last_gnt;
   logic    r_err;

   // Round-robin: a lone requester always wins; on contention the one not granted last wins.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (req0_val_i && req1_val_i) begin
         w_gnt0 = (r_last_gnt == REQ_ID1);
         w_gnt1 = (r_last_gnt == REQ_ID0);
      end else begin
         w_gnt0 = req0_val_i;
         w_gnt1 = req1_val_i;
      end
   end

   assign w_gnt_id = w_gnt1 ? REQ_ID1 : REQ_ID0;

   // Issue channel; reset gating keeps every handshake output low while reset is held.
   assign p_val_o    = reset & (req0_val_i | req1_val_i) & ~w_full;
   assign p_data_o   = w_gnt1 ? req1_data_i : req0_data_i;
   assign req0_rdy_o = reset & w_gnt0 & p_rdy_i & ~w_full;
   assign req1_rdy_o = reset & w_gnt1 & p_rdy_i & ~w_full;
   assign w_issue    = p_val_o & p_rdy_i;

   // Result channel is steered by the oldest outstanding tag; nothing is accepted with no tag.
   assign w_head_rdy   = (w_head == REQ_ID1) ? resp1_rdy_i : resp0_rdy_i;
   assign p_rdy_o      = reset & ~w_empty & w_head_rdy;
   assign resp0_val_o  = reset & ~w_empty & p_val_i & (w_head == REQ_ID0);
   assign resp1_val_o  = reset & ~w_empty & p_val_i & (w_head == REQ_ID1);
   assign resp0_data_o = p_data_i;
   assign resp1_data_o = p_data_i;
   assign w_result     = p_val_i & p_rdy_o;

   perceptron_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_issue),
      .i_push_id (w_gnt_id),
      .i_pop     (w_result),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_head    (w_head)
   );

   // Last grant moves only on a completed issue, so a stalled grant stays put; req0 wins first contention.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_gnt <= REQ_ID1;
      end else if (w_issue) begin
         r_last_gnt <= w_gnt_id;
      end
   end

   // A result offered with no outstanding tag is a protocol error; latch it until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (p_val_i && w_empty) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;

`ifdef PERCEPTRON_ARB_STATS_EN
   logic [15:0] r_gnt_cnt0;
   logic [15:0] r_gnt_cnt1;

   // Per-requester issue counters, saturating rather than wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gnt_cnt0 <= '0;
         r_gnt_cnt1 <= '0;
      end else if (w_issue) begin
         if (w_gnt0 && (r_gnt_cnt0 != P_CNT_MAX)) begin
            r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
         end
         if (w_gnt1 && (r_gnt_cnt1 != P_CNT_MAX)) begin
            r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
         end
      end
   end

   assign gnt_cnt0_o = r_gnt_cnt0;
   assign gnt_cnt1_o = r_gnt_cnt1;
`else
   assign gnt_cnt0_o = 16'd0;
   assign gnt_cnt1_o = 16'd0;
`endif

endmodule

// File: tb/tb_perceptron_arb.sv
// Directed bench for perceptron_arb with issue/response scoreboards checked by a negedge monitor.
// Latency: expectations assume 0-cycle issue and routing.
// Backpressure: exercises p_rdy_i, resp ready stalls and tag FIFO full.
`timescale 1ns/1ps
module tb_perceptron_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_val, req1_val;
   logic [7:0]  req0_data, req1_data;
   logic        req0_rdy, req1_rdy;
   logic        p_val_o, p_rdy_i, p_val_i, p_rdy_o;
   logic [7:0]  p_data_o, p_data_i;
   logic        resp0_val, resp1_val, resp0_rdy, resp1_rdy;
   logic [7:0]  resp0_data, resp1_data;
   logic        err;
   logic [15:0] gnt_cnt0, gnt_cnt1;

   int n_vec = 0;
   int n_err = 0;

   logic [8:0]  exp_iss[$];
   logic [8:0]  exp_rsp[$];
   logic [8:0]  e_iss;
   logic [8:0]  e_rsp;
   logic [15:0] exp_cnt2;

   always #5 clk = ~clk;

   perceptron_arb dut (
      .clk          (clk),
      .reset        (reset),
      .req0_val_i   (req0_val),
      .req0_data_i  (req0_data),
      .req0_rdy_o   (req0_rdy),
      .req1_val_i   (req1_val),
      .req1_data_i  (req1_data),
      .req1_rdy_o   (req1_rdy),
      .p_val_o      (p_val_o),
      .p_data_o     (p_data_o),
      .p_rdy_i      (p_rdy_i),
      .p_val_i      (p_val_i),
      .p_data_i     (p_data_i),
      .p_rdy_o      (p_rdy_o),
      .resp0_val_o  (resp0_val),
      .resp0_data_o (resp0_data),
      .resp0_rdy_i  (resp0_rdy),
      .resp1_val_o  (resp1_val),
      .resp1_data_o (resp1_data),
      .resp1_rdy_i  (resp1_rdy),
      .err_o        (err),
      .gnt_cnt0_o   (gnt_cnt0),
      .gnt_cnt1_o   (gnt_cnt1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Monitor: every handshake that will complete on the next rising edge is popped and compared.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (p_val_o && p_rdy_i) begin
            if (exp_iss.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL iss_unexpected: got id %0d data %0h, expected no issue", req1_rdy, p_data_o);
            end else begin
               e_iss = exp_iss.pop_front();
               chk("iss_rdy1", {31'b0, req1_rdy}, {31'b0, e_iss[8]});
               chk("iss_rdy0", {31'b0, req0_rdy}, {31'b0, ~e_iss[8]});
               chk("iss_data", {24'b0, p_data_o}, {24'b0, e_iss[7:0]});
            end
         end
         if ((resp0_val && resp0_rdy) || (resp1_val && resp1_rdy)) begin
            if (exp_rsp.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rsp_unexpected: got resp0_val %0d resp1_val %0d data %0h, expected none",
                        resp0_val, resp1_val, p_data_i);
            end else begin
               e_rsp = exp_rsp.pop_front();
               chk("rsp_chan1", {31'b0, resp1_val}, {31'b0, e_rsp[8]});
               chk("rsp_chan0", {31'b0, resp0_val}, {31'b0, ~e_rsp[8]});
               chk("rsp_data", {24'b0, (e_rsp[8] ? resp1_data : resp0_data)}, {24'b0, e_rsp[7:0]});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef PERCEPTRON_ARB_STATS_EN
      exp_cnt2 = 16'd2;
`else
      exp_cnt2 = 16'd0;
`endif
      // Reset held with live inputs: every handshake output must stay low.
      reset = 1'b0;  req0_val = 1'b1; req1_val = 1'b0; req0_data = 8'h55; req1_data = 8'h00;
      p_rdy_i = 1'b1; p_val_i = 1'b1; p_data_i = 8'h99; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      #2;
      chk("rst_p_val",   {31'b0, p_val_o},   0);
      chk("rst_rdy0",    {31'b0, req0_rdy},  0);
      chk("rst_p_rdy",   {31'b0, p_rdy_o},   0);
      chk("rst_resp0",   {31'b0, resp0_val}, 0);
      chk("rst_resp1",   {31'b0, resp1_val}, 0);
      chk("rst_err",     {31'b0, err},       0);
      chk("rst_cnt0",    {16'b0, gnt_cnt0},  0);
      chk("rst_cnt1",    {16'b0, gnt_cnt1},  0);
      step(); step();
      req0_val = 1'b0; p_val_i = 1'b0;
      reset = 1'b1;
      settle();
      chk("rel_err", {31'b0, err}, 0);

      // Contention for 4 cycles: req0, req1, req0, req1; fills the 4-deep tag FIFO.
      for (int k = 0; k < 4; k++) begin
         step();
         req0_val = 1'b1; req1_val = 1'b1;
         req0_data = 8'h10 + 8'(k); req1_data = 8'h20 + 8'(k);
         exp_iss.push_back((k % 2 == 1) ? {1'b1, req1_data} : {1'b0, req0_data});
      end
      step();
      settle();
      chk("full_p_val", {31'b0, p_val_o},  0);
      chk("full_rdy0",  {31'b0, req0_rdy}, 0);
      chk("full_rdy1",  {31'b0, req1_rdy}, 0);
      chk("cnt0_after4", {16'b0, gnt_cnt0}, {16'b0, exp_cnt2});
      chk("cnt1_after4", {16'b0, gnt_cnt1}, {16'b0, exp_cnt2});
      // A pop while full must not let an issue through in the same cycle.
      step();
      p_val_i = 1'b1; p_data_i = 8'h40; exp_rsp.push_back({1'b0, 8'h40});
      settle();
      chk("pop_full_p_val", {31'b0, p_val_o}, 0);
      chk("pop_full_p_rdy", {31'b0, p_rdy_o}, 1);
      step();
      p_val_i = 1'b0; req0_data = 8'h14; req1_data = 8'h24;
      exp_iss.push_back({1'b0, 8'h14});
      settle();
      chk("fifth_p_val", {31'b0, p_val_o}, 1);
      step();
      req0_val = 1'b0; req1_val = 1'b0;

      // Head tag is req1 and resp1 is not ready: result held until ready.
      resp1_rdy = 1'b0; p_val_i = 1'b1; p_data_i = 8'h51;
      settle();
      chk("hold_p_rdy",   {31'b0, p_rdy_o},    0);
      chk("hold_resp1",   {31'b0, resp1_val},  1);
      chk("hold_resp0",   {31'b0, resp0_val},  0);
      chk("hold_data1",   {24'b0, resp1_data}, 32'h51);
      step();
      settle();
      chk("hold2_p_rdy",  {31'b0, p_rdy_o},    0);
      step();
      resp1_rdy = 1'b1; exp_rsp.push_back({1'b1, 8'h51});
      settle();
      chk("release_p_rdy", {31'b0, p_rdy_o}, 1);
      step();
      // Simultaneous issue and result.
      req1_val = 1'b1; req1_data = 8'h33; exp_iss.push_back({1'b1, 8'h33});
      p_data_i = 8'h62; exp_rsp.push_back({1'b0, 8'h62});
      settle();
      chk("simul_p_val", {31'b0, p_val_o}, 1);
      chk("simul_p_rdy", {31'b0, p_rdy_o}, 1);
      step();
      req1_val = 1'b0;
      // Drain remaining tags [1,0,1].
      for (int j = 0; j < 3; j++) begin
         p_data_i = 8'h71 + 8'(j);
         exp_rsp.push_back({(j % 2 == 0), p_data_i});
         step();
      end
      p_val_i = 1'b0;
      settle();
      chk("drained_p_rdy", {31'b0, p_rdy_o}, 0);
      chk("drained_err",   {31'b0, err},     0);

      // Two tags in flight, then an asynchronous reset between edges.
      step();
      req0_val = 1'b1; req0_data = 8'h81; exp_iss.push_back({1'b0, 8'h81});
      step();
      req0_val = 1'b0; req1_val = 1'b1; req1_data = 8'h92; exp_iss.push_back({1'b1, 8'h92});
      step();
      req1_val = 1'b0;
      #2;
      reset = 1'b0; req0_val = 1'b1; req1_val = 1'b1; p_val_i = 1'b1;
      #1;
      chk("ar_p_val", {31'b0, p_val_o},   0);
      chk("ar_rdy0",  {31'b0, req0_rdy},  0);
      chk("ar_rdy1",  {31'b0, req1_rdy},  0);
      chk("ar_p_rdy", {31'b0, p_rdy_o},   0);
      chk("ar_resp0", {31'b0, resp0_val}, 0);
      chk("ar_resp1", {31'b0, resp1_val}, 0);
      chk("ar_cnt0",  {16'b0, gnt_cnt0},  0);
      step();
      p_val_i = 1'b0;
      reset = 1'b1;
      req0_data = 8'hC0; req1_data = 8'hD0; exp_iss.push_back({1'b0, 8'hC0});
      step();
      req0_data = 8'hC1; req1_data = 8'hD1; exp_iss.push_back({1'b1, 8'hD1});
      step();
      req0_val = 1'b0; req1_val = 1'b0;
      p_val_i = 1'b1; p_data_i = 8'hA1; exp_rsp.push_back({1'b0, 8'hA1});
      step();
      p_data_i = 8'hA2; exp_rsp.push_back({1'b1, 8'hA2});
      step();
      p_val_i = 1'b0;

      // Single requester, result returned to resp0 only.
      req0_val = 1'b1; req0_data = 8'h15; exp_iss.push_back({1'b0, 8'h15});
      settle();
      chk("one_p_data", {24'b0, p_data_o}, 32'h15);
      chk("one_p_val",  {31'b0, p_val_o},  1);
      step();
      req0_val = 1'b0;
      p_val_i = 1'b1; p_data_i = 8'h2A; exp_rsp.push_back({1'b0, 8'h2A});
      settle();
      chk("one_resp0",  {31'b0, resp0_val},  1);
      chk("one_resp1",  {31'b0, resp1_val},  0);
      chk("one_data0",  {24'b0, resp0_data}, 32'h2A);
      step();
      p_val_i = 1'b0;

      // Result with no outstanding tag: refused and flagged from the next edge until reset.
      p_val_i = 1'b1; p_data_i = 8'hEE;
      settle();
      chk("err_p_rdy",  {31'b0, p_rdy_o},   0);
      chk("err_before", {31'b0, err},       0);
      chk("err_resp0",  {31'b0, resp0_val}, 0);
      step();
      p_val_i = 1'b0;
      settle();
      chk("err_set", {31'b0, err}, 1);
      step(); step();
      settle();
      chk("err_sticky", {31'b0, err}, 1);
      step();
      reset = 1'b0;
      #1;
      chk("err_clear", {31'b0, err}, 0);
      step();
      reset = 1'b1;
      settle();
      chk("err_after_rel", {31'b0, err}, 0);

      chk("iss_queue_empty", exp_iss.size(), 0);
      chk("rsp_queue_empty", exp_rsp.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
